// File: rtl/irq_ack_decoder_if.sv
// Grant/acknowledge bus between the priority encoder, the interrupt sources and irq_ack_decoder.
interface irq_ack_decoder_if #(
    parameter int unsigned NUM_CH = 27,
    parameter int unsigned ID_W   = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic              grant_rdy;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] ack;
    logic              svc_vld;
    logic [ID_W-1:0]   svc_id;
    logic              svc_done;
    logic              err_bad_id;
    logic              err_timeout;
    logic [CNT_W-1:0]  svc_cnt;

    modport master (
        output grant_vld, grant_id, req, svc_done,
        input  grant_rdy, ack, svc_vld, svc_id, err_bad_id, err_timeout, svc_cnt
    );

    modport slave (
        input  grant_vld, grant_id, req, svc_done,
        output grant_rdy, ack, svc_vld, svc_id, err_bad_id, err_timeout, svc_cnt
    );
endinterface

// File: rtl/irq_ack_decoder.sv
// Acknowledge side of the priority interrupt encoder: latches a granted channel,
// drives a one-hot ack until the handler completes, then waits for the request to drop.
module irq_ack_decoder #(
    parameter int unsigned NUM_CH  = 27,
    parameter int unsigned ID_W    = 5,
    parameter int unsigned DROP_TO = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_ack_decoder_if.slave  bus
);
    localparam int unsigned DW = $clog2(DROP_TO);
    localparam logic [DW-1:0] DROP_LAST = DW'(DROP_TO - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_DROP} state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_svc_id;
    logic [DW-1:0]    r_drop_cnt;
    logic [CNT_W-1:0] r_svc_cnt;
    logic             r_err_bad_id;
    logic             r_err_timeout;

    state_t           w_state_nxt;
    logic [ID_W-1:0]  w_svc_id_nxt;
    logic [DW-1:0]    w_drop_cnt_nxt;
    logic [CNT_W-1:0] w_svc_cnt_nxt;
    logic             w_err_bad_id_nxt;
    logic             w_err_timeout_nxt;
    logic             w_id_ok;
    logic             w_req_hit;

    assign w_id_ok   = 32'(bus.grant_id) < NUM_CH;
    assign w_req_hit = bus.req[r_svc_id];

    // State and registered side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_svc_id      <= '0;
            r_drop_cnt    <= '0;
            r_svc_cnt     <= '0;
            r_err_bad_id  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_svc_id      <= w_svc_id_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
            r_svc_cnt     <= w_svc_cnt_nxt;
            r_err_bad_id  <= w_err_bad_id_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_svc_id_nxt      = r_svc_id;
        w_drop_cnt_nxt    = r_drop_cnt;
        w_svc_cnt_nxt     = r_svc_cnt;
        w_err_bad_id_nxt  = 1'b0;
        w_err_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.grant_vld) begin
                    if (w_id_ok) begin
                        w_svc_id_nxt = bus.grant_id;
                        w_state_nxt  = S_ACK;
                    end else begin
                        w_err_bad_id_nxt = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (bus.svc_done) begin
                    w_state_nxt    = S_DROP;
                    w_drop_cnt_nxt = '0;
                    if (r_svc_cnt != '1) w_svc_cnt_nxt = r_svc_cnt + CNT_W'(1);
                end
            end
            S_DROP: begin
                // A drop seen on the limit cycle takes priority over the timeout
                if (!w_req_hit) begin
                    w_state_nxt = S_IDLE;
                end else if (r_drop_cnt == DROP_LAST) begin
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_drop_cnt_nxt = r_drop_cnt + DW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded only from registers so reset clears ack immediately
    assign bus.grant_rdy   = (r_state == S_IDLE);
    assign bus.svc_vld     = (r_state == S_ACK);
    assign bus.ack         = (r_state == S_ACK) ? (NUM_CH'(1) << r_svc_id) : '0;
    assign bus.svc_id      = r_svc_id;
    assign bus.svc_cnt     = r_svc_cnt;
    assign bus.err_bad_id  = r_err_bad_id;
    assign bus.err_timeout = r_err_timeout;
endmodule

// File: tb/tb_irq_ack_decoder.sv
// Directed bench for irq_ack_decoder: grant/ack/drop flow, bad IDs, timeout, async reset, saturation.
module tb_irq_ack_decoder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    irq_ack_decoder_if #(.NUM_CH(27), .ID_W(5), .CNT_W(16)) bus ();
    irq_ack_decoder_if #(.NUM_CH(27), .ID_W(5), .CNT_W(4))  sbus ();

    irq_ack_decoder #(.NUM_CH(27), .ID_W(5), .DROP_TO(16), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    irq_ack_decoder #(.NUM_CH(27), .ID_W(5), .DROP_TO(16), .CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.grant_vld = 1'b0; bus.grant_id = '0; bus.req = '0; bus.svc_done = 1'b0;
        sbus.grant_vld = 1'b0; sbus.grant_id = '0; sbus.req = '0; sbus.svc_done = 1'b0;

        // Reset values
        #2;
        check("rst_grant_rdy", 32'(bus.grant_rdy), 32'd1);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_svc_vld", 32'(bus.svc_vld), 32'd0);
        check("rst_svc_id", 32'(bus.svc_id), 32'd0);
        check("rst_errs", {30'd0, bus.err_bad_id, bus.err_timeout}, 32'd0);
        check("rst_svc_cnt", 32'(bus.svc_cnt), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Basic service of channel 5
        bus.grant_vld = 1'b1; bus.grant_id = 5'd5; bus.req = 27'h20;
        tick();
        bus.grant_vld = 1'b0;
        check("t1_ack", 32'(bus.ack), 32'h20);
        check("t1_svc_vld", 32'(bus.svc_vld), 32'd1);
        check("t1_grant_rdy", 32'(bus.grant_rdy), 32'd0);
        check("t1_svc_id", 32'(bus.svc_id), 32'd5);
        tick(); tick();
        check("t1_ack_hold", 32'(bus.ack), 32'h20);
        bus.svc_done = 1'b1;
        tick();
        bus.svc_done = 1'b0;
        check("t1_ack_off", 32'(bus.ack), 32'd0);
        check("t1_cnt", 32'(bus.svc_cnt), 32'd1);
        check("t1_drop_rdy", 32'(bus.grant_rdy), 32'd0);
        bus.req = '0;
        tick();
        check("t1_idle_rdy", 32'(bus.grant_rdy), 32'd1);
        check("t1_no_to", 32'(bus.err_timeout), 32'd0);

        // Out-of-range IDs, back to back
        bus.grant_vld = 1'b1; bus.grant_id = 5'd27;
        tick();
        check("bad27_pulse", 32'(bus.err_bad_id), 32'd1);
        check("bad27_ack", 32'(bus.ack), 32'd0);
        bus.grant_id = 5'd31;
        tick();
        bus.grant_vld = 1'b0;
        check("bad31_pulse", 32'(bus.err_bad_id), 32'd1);
        check("bad31_idle", 32'(bus.grant_rdy), 32'd1);
        check("bad31_svc_id", 32'(bus.svc_id), 32'd5);
        tick();
        check("bad_pulse_end", 32'(bus.err_bad_id), 32'd0);
        check("bad_ack", 32'(bus.ack), 32'd0);

        // Timeout with req[3] held
        bus.grant_vld = 1'b1; bus.grant_id = 5'd3; bus.req = 27'h8;
        tick();
        bus.grant_vld = 1'b0; bus.svc_done = 1'b1;
        tick();
        bus.svc_done = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_wait_err", 32'(bus.err_timeout), 32'd0);
            check("to_wait_rdy", 32'(bus.grant_rdy), 32'd0);
        end
        tick();
        check("to_pulse", 32'(bus.err_timeout), 32'd1);
        check("to_idle", 32'(bus.grant_rdy), 32'd1);
        bus.req = '0;
        tick();
        check("to_pulse_end", 32'(bus.err_timeout), 32'd0);

        // Request drops on the limit cycle: no timeout
        bus.grant_vld = 1'b1; bus.grant_id = 5'd3; bus.req = 27'h8;
        tick();
        bus.grant_vld = 1'b0; bus.svc_done = 1'b1;
        tick();
        bus.svc_done = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        bus.req = '0;
        tick();
        check("late_drop_no_to", 32'(bus.err_timeout), 32'd0);
        check("late_drop_idle", 32'(bus.grant_rdy), 32'd1);
        check("late_drop_cnt", 32'(bus.svc_cnt), 32'd3);

        // Asynchronous reset while ack[12] is high
        bus.grant_vld = 1'b1; bus.grant_id = 5'd12; bus.req = 27'h1000;
        tick();
        bus.grant_vld = 1'b0;
        check("ar_ack", 32'(bus.ack), 32'h1000);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ack_async", 32'(bus.ack), 32'd0);
        check("ar_svc_vld", 32'(bus.svc_vld), 32'd0);
        #1 rst_n = 1'b1;
        bus.req = '0;
        tick();
        check("ar_rdy", 32'(bus.grant_rdy), 32'd1);
        check("ar_cnt", 32'(bus.svc_cnt), 32'd0);

        // svc_done in IDLE ignored; grant held during ACK ignored
        bus.svc_done = 1'b1;
        tick();
        bus.svc_done = 1'b0;
        check("idle_done_rdy", 32'(bus.grant_rdy), 32'd1);
        check("idle_done_cnt", 32'(bus.svc_cnt), 32'd0);
        bus.grant_vld = 1'b1; bus.grant_id = 5'd7;
        tick();
        bus.grant_id = 5'd9;
        tick();
        check("hold_svc_id", 32'(bus.svc_id), 32'd7);
        check("hold_ack", 32'(bus.ack), 32'h80);
        bus.svc_done = 1'b1;
        tick();
        bus.svc_done = 1'b0;
        check("hold_drop_rdy", 32'(bus.grant_rdy), 32'd0);
        tick();
        check("hold_idle_rdy", 32'(bus.grant_rdy), 32'd1);
        check("hold_idle_id", 32'(bus.svc_id), 32'd7);
        tick();
        bus.grant_vld = 1'b0;
        check("second_grant_id", 32'(bus.svc_id), 32'd9);
        check("second_grant_ack", 32'(bus.ack), 32'h200);
        check("second_cnt", 32'(bus.svc_cnt), 32'd1);

        // Saturating service counter on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            sbus.grant_vld = 1'b1; sbus.grant_id = 5'(i % 27);
            tick();
            sbus.grant_vld = 1'b0; sbus.svc_done = 1'b1;
            tick();
            sbus.svc_done = 1'b0;
            tick();
            if (i == 13) check("sat_cnt14", 32'(sbus.svc_cnt), 32'd14);
            if (i == 14) check("sat_cnt15", 32'(sbus.svc_cnt), 32'd15);
        end
        check("sat_cnt20", 32'(sbus.svc_cnt), 32'd15);
        check("sat_idle", 32'(sbus.grant_rdy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/irq_ack_decoder.md
# irq_ack_decoder

Sequential acknowledge side of the 27-channel priority interrupt encoder. It accepts the encoder's winning channel ID through a valid/ready handshake, latches it, and drives a one-hot acknowledge back to that source. It then holds the channel in service until the handler signals completion and the source drops its request. It sits between the combinational priority encoder and the per-source interrupt lines, and adds the state the combinational encoder lacks.

## Interface
- NUM_CH, 27, number of interrupt sources; legal IDs are 0..NUM_CH-1
- ID_W, 5, channel ID width; must satisfy 2^ID_W >= NUM_CH
- DROP_TO, 16, maximum cycles to wait for the request to drop after completion (>=2)
- CNT_W, 16, width of the service counter
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- grant_vld  in  1  encoder presents a winning channel
- grant_id  in  ID_W  winning channel ID
- grant_rdy  out  1  block can accept a grant (high only in IDLE)
- req  in  NUM_CH  raw request lines from the sources
- ack  out  NUM_CH  one-hot acknowledge to the serviced source
- svc_vld  out  1  a channel is under service (high in ACK)
- svc_id  out  ID_W  latched channel ID
- svc_done  in  1  handler finished servicing
- err_bad_id  out  1  one-cycle pulse: an out-of-range ID was offered
- err_timeout  out  1  one-cycle pulse: the request did not drop within DROP_TO
- svc_cnt  out  CNT_W  completed services, saturating

## Operation
- States: IDLE, ACK, DROP.
- IDLE:
  - grant_rdy=1. A grant is accepted when grant_vld & grant_rdy.
  - If grant_id >= NUM_CH: pulse err_bad_id, remain in IDLE, latch nothing.
  - Otherwise: latch svc_id=grant_id and go to ACK.
- ACK:
  - ack[svc_id]=1, all other ack bits 0, svc_vld=1.
  - On svc_done=1: go to DROP and increment svc_cnt, saturating at 2^CNT_W-1.
- DROP:
  - ack=0, svc_vld=0. A drop counter clears on entry and increments each cycle in which req[svc_id]=1.
  - If req[svc_id]=0: go to IDLE.
  - Else if the drop counter = DROP_TO-1: pulse err_timeout and go to IDLE.
- Outputs are registered. ack is decoded from the registered state and svc_id, with no combinational path from any input.
- svc_done outside ACK is ignored. grant_vld outside IDLE is ignored (grant_rdy=0).
- req bits other than svc_id have no effect.
- svc_id holds its last value in IDLE.

## Timing
- Reset values: grant_rdy=1, ack=0, svc_vld=0, svc_id=0, err_bad_id=0, err_timeout=0, svc_cnt=0, state IDLE, drop counter 0.
- Reset is asynchronous and takes effect immediately, including mid-ACK: ack falls without waiting for a clock edge.
- Grant accepted at edge T → ack and svc_vld high from T+1, grant_rdy low from T+1.
- svc_done sampled high at edge T → ack low at T+1, svc_cnt updated at T+1.
- svc_done is accepted on the first ACK cycle: the minimum ACK dwell is 1 cycle.
- DROP with req[svc_id]=0 on the first sample → IDLE one cycle after entry, grant_rdy high again.
- Minimum grant-to-grant spacing is 3 cycles.
- Timeout: with req held high, err_timeout pulses coincident with the return to IDLE, DROP_TO cycles after DROP entry.
- If req drops on the same cycle the counter reaches its limit, the drop wins: no err_timeout.
- err_bad_id is asserted in the cycle after the rejected offer, for exactly 1 cycle. A back-to-back bad ID produces one pulse per offer.

## Test plan
- Reset, then grant_id=5 → ack=0x20 one cycle later. Hold svc_done at cycle 4 → ack=0 next cycle, svc_cnt=1. Drop req[5] → grant_rdy=1.
- grant_id=27 and grant_id=31 offered → err_bad_id pulses twice, ack stays 0, state stays IDLE.
- Hold req[3]=1 after svc_done with DROP_TO=16 → err_timeout pulses exactly 16 cycles after DROP entry. Separately, drop req[3] on cycle 16 → no pulse.
- Assert rst_n=0 asynchronously while ack[12]=1 → ack=0 before the next edge. After release, grant_rdy=1 and svc_cnt=0.
- Run CNT_W=4 with 20 services → svc_cnt saturates at 15.
- Pulse svc_done in IDLE and hold grant_vld high during ACK → no state change, and the second grant is accepted only after returning to IDLE.
